// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Operand-issue and write-back stage in front of an external combinational
// 32-bit ALU. Holds a 32x32 register file (r0 hard-wired to zero), accepts one
// instruction per valid/ready handshake, presents registered operands to the
// ALU, and writes the ALU result back one cycle later.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   instruction handshake
//   in_ld                 1 = load immediate, 0 = ALU operation
//   in_op                 ALU op (000 and, 001 or, 010 add, 110 sub, 111 slt)
//   in_rs, in_rt, in_rd   source A, source B, destination register
//   in_imm                immediate for loads
//   alu_a, alu_b, alu_op  registered operands/op towards the ALU
//   alu_z                 combinational ALU result
//   out_valid             one-cycle pulse: write-back done
//   out_rd, out_data      destination and value just written
//   out_err               one-cycle pulse: illegal op rejected
//   dbg_addr, dbg_data    combinational debug read port (r0 reads 0)
module alu_issue_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_ld,
    input  logic [2:0]   in_op,
    input  logic [4:0]   in_rs,
    input  logic [4:0]   in_rt,
    input  logic [4:0]   in_rd,
    input  logic [W-1:0] in_imm,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_z,
    output logic         out_valid,
    output logic [4:0]   out_rd,
    output logic [W-1:0] out_data,
    output logic         out_err,
    input  logic [4:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   rf [0:31];
    logic [4:0]     rd_p0;
    logic           accept;
    logic           op_legal;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == WB);

    always_comb begin
        op_legal = 1'b0;
        case (in_op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    // r0 is never written, but the mux keeps the zero read explicit.
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_ld)
                        state_nxt = WB;
                    else if (op_legal)
                        state_nxt = EXEC;
                    // illegal op: stay in IDLE, only out_err pulses
                end
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 3'b000;
            rd_p0    <= 5'd0;
            out_rd   <= 5'd0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            out_err <= 1'b0;
            // issue stage: load writes immediately, ALU op captures operands
            if (accept) begin
                if (in_ld) begin
                    if (in_rd != 5'd0)
                        rf[in_rd] <= in_imm;
                    out_rd   <= in_rd;
                    out_data <= in_imm;
                end else if (op_legal) begin
                    alu_a  <= (in_rs == 5'd0) ? '0 : rf[in_rs];
                    alu_b  <= (in_rt == 5'd0) ? '0 : rf[in_rt];
                    alu_op <= in_op;
                    rd_p0  <= in_rd;
                end else begin
                    out_err <= 1'b1;
                end
            end
            // write-back stage: ALU result lands in the register file
            if (state == EXEC) begin
                if (rd_p0 != 5'd0)
                    rf[rd_p0] <= alu_z;
                out_rd   <= rd_p0;
                out_data <= alu_z;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ld;
    logic [2:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_z;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_unit #(.W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ld    (in_ld),
        .in_op    (in_op),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_imm   (in_imm),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_z    (alu_z),
        .out_valid(out_valid),
        .out_rd   (out_rd),
        .out_data (out_data),
        .out_err  (out_err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_z = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic dbg_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Present one instruction at the negedge; return 1 ns after the accepting edge.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
        @(negedge clk);
        check("ready_before_issue", in_ready, 1'b1);
        in_valid = 1'b1;
        in_ld    = ld;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] imm);
        issue(1'b1, 3'b000, 5'd0, 5'd0, rd, imm);
        check("ld_valid", out_valid, 1'b1);
        check("ld_rd", out_rd, rd);
        check("ld_data", out_data, imm);
        check("ld_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("ld_valid_end", out_valid, 1'b0);
        check("ld_ready_back", in_ready, 1'b1);
    endtask

    task automatic do_alu(input string tag, input logic [2:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] exp);
        issue(1'b0, op, rs, rt, rd, 32'h0);
        check({tag, "_exec_ready"}, in_ready, 1'b0);
        check({tag, "_exec_valid"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_wb_valid"}, out_valid, 1'b1);
        check({tag, "_wb_rd"}, out_rd, rd);
        check({tag, "_wb_data"}, out_data, exp);
        check({tag, "_wb_ready"}, in_ready, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_idle_valid"}, out_valid, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    task automatic do_illegal(input logic [2:0] op, input logic [4:0] rd);
        issue(1'b0, op, 5'd1, 5'd2, rd, 32'h0);
        check("ill_err", out_err, 1'b1);
        check("ill_valid", out_valid, 1'b0);
        check("ill_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("ill_err_end", out_err, 1'b0);
        check("ill_valid_end", out_valid, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ld    = 1'b0;
        in_op    = 3'b000;
        in_rs    = 5'd0;
        in_rt    = 5'd0;
        in_rd    = 5'd0;
        in_imm   = 32'h0;
        dbg_addr = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_rd", out_rd, 5'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_alu_op", alu_op, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1'b1);
        for (int a = 0; a < 32; a++)
            dbg_chk("rst_dbg", a[4:0], 32'h0);

        // Loads then add
        do_load(5'd1, 32'd5);
        do_load(5'd2, 32'd7);
        dbg_chk("dbg_r1", 5'd1, 32'd5);
        dbg_chk("dbg_r2", 5'd2, 32'd7);
        do_alu("add", 3'b010, 5'd1, 5'd2, 5'd3, 32'd12);
        dbg_chk("dbg_r3", 5'd3, 32'd12);

        // Sub / slt / and / or
        do_alu("sub", 3'b110, 5'd1, 5'd2, 5'd4, 32'hFFFF_FFFE);
        dbg_chk("dbg_r4", 5'd4, 32'hFFFF_FFFE);
        do_alu("slt", 3'b111, 5'd1, 5'd2, 5'd5, 32'd1);
        dbg_chk("dbg_r5", 5'd5, 32'd1);
        // signed compare: r4 = -2 < r1 = 5
        do_alu("slt_neg", 3'b111, 5'd4, 5'd1, 5'd10, 32'd1);
        do_alu("slt_false", 3'b111, 5'd2, 5'd1, 5'd11, 32'd0);
        do_alu("and", 3'b000, 5'd1, 5'd2, 5'd6, 32'd5);
        dbg_chk("dbg_r6", 5'd6, 32'd5);
        do_alu("or", 3'b001, 5'd1, 5'd2, 5'd7, 32'd7);
        dbg_chk("dbg_r7", 5'd7, 32'd7);

        // r0 is hard-wired to zero
        do_load(5'd0, 32'h0000_DEAD);
        dbg_chk("dbg_r0", 5'd0, 32'h0);
        do_alu("r0_src", 3'b010, 5'd0, 5'd2, 5'd8, 32'd7);
        do_alu("r0_dst", 3'b010, 5'd1, 5'd2, 5'd0, 32'd12);
        dbg_chk("dbg_r0_after", 5'd0, 32'h0);

        // Back-to-back read-after-write
        do_load(5'd1, 32'd5);
        do_alu("raw", 3'b010, 5'd1, 5'd1, 5'd1, 32'd10);
        dbg_chk("dbg_r1_raw", 5'd1, 32'd10);

        // Illegal ops: register file untouched, next accept the following cycle
        do_illegal(3'b011, 5'd2);
        do_illegal(3'b100, 5'd2);
        do_illegal(3'b101, 5'd2);
        dbg_chk("ill_r2", 5'd2, 32'd7);
        check("ill_out_rd_kept", out_rd, 5'd1);
        check("ill_out_data_kept", out_data, 32'd10);

        // Reset during EXEC aborts the write
        issue(1'b0, 3'b010, 5'd1, 5'd2, 5'd3, 32'h0);
        check("abort_exec_ready", in_ready, 1'b0);
        check("abort_alu_a", alu_a, 32'd10);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", out_valid, 1'b0);
        check("abort_state_idle", in_ready, 1'b1);
        check("abort_alu_a_clr", alu_a, 32'h0);
        check("abort_out_data", out_data, 32'h0);
        dbg_chk("abort_r3", 5'd3, 32'h0);
        dbg_chk("abort_r1", 5'd1, 32'h0);
        @(posedge clk);
        #1;
        check("abort_valid_hold", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_valid_after", out_valid, 1'b0);
        check("abort_ready_after", in_ready, 1'b1);
        dbg_chk("abort_r3_after", 5'd3, 32'h0);

        // Function after reset
        do_load(5'd1, 32'd3);
        do_load(5'd2, 32'd4);
        do_alu("post_sub", 3'b110, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFF);
        dbg_chk("dbg_r9", 5'd9, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
